// File: rtl/push_conditioner_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Defaults assume a 50 MHz system clock.
package push_conditioner_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM_ON  = 3'd1,
        HELD    = 3'd2,
        REPEAT  = 3'd3,
        ARM_OFF = 3'd4
    } btn_state_e;

    localparam int N_BTN_DEF         = 3;
    localparam int DB_CYCLES_DEF     = 1_000_000;
    localparam int REPEAT_DELAY_DEF  = 25_000_000;
    localparam int REPEAT_PERIOD_DEF = 5_000_000;
    localparam int CNT_W_DEF         = 25;

endpackage

// File: rtl/push_conditioner_if.sv
// Button bundle between the board pins and pixelGeneration.
// The master drives the raw buttons; the slave returns the conditioned outputs.
interface push_conditioner_if
    import push_conditioner_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF
);
    logic [N_BTN-1:0] push;
    logic [N_BTN-1:0] push_level;
    logic [N_BTN-1:0] push_tick;
    logic [N_BTN-1:0] push_release;

    modport master (
        output push,
        input  push_level,
        input  push_tick,
        input  push_release
    );

    modport slave (
        input  push,
        output push_level,
        output push_tick,
        output push_release
    );
endinterface

// File: rtl/push_conditioner_debounce_fsm.sv
// One button: two-flop synchronizer, debounce/repeat FSM and registered outputs.
// DB_CYCLES must be at least 2.
module push_conditioner_debounce_fsm
    import push_conditioner_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    output logic level_o,
    output logic tick_o,
    output logic release_o
);

    // The sample that moves the FSM into an arming state is the first stable one.
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 2);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             sync1_q, sync_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             tick_q, tick_d;
    logic             release_q, release_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= push_i;
            sync_q  <= sync1_q;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_ONE;
        level_d   = level_q;
        tick_d    = 1'b0;
        release_d = 1'b0;

        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                cnt_d   = '0;
                if (sync_q) state_d = ARM_ON;
            end
            ARM_ON: begin
                if (!sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            HELD: begin
                if (!sync_q) begin
                    state_d = ARM_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == DELAY_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                end
            end
            REPEAT: begin
                if (!sync_q) begin
                    state_d = ARM_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == PERIOD_LAST) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                end
            end
            ARM_OFF: begin
                // A bounce back high restarts the repeat delay without a new tick.
                if (sync_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            tick_q    <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            tick_q    <= tick_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign tick_o    = tick_q;
    assign release_o = release_q;

endmodule

// File: rtl/push_conditioner.sv
// Conditions the raw push buttons for pixelGeneration: one independent
// debounce/repeat channel per button, outputs concatenated onto the bus.
module push_conditioner
    import push_conditioner_pkg::*;
#(
    parameter int N_BTN         = N_BTN_DEF,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    push_conditioner_if.slave   bus
);

    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] tick_w;
    logic [N_BTN-1:0] release_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        push_conditioner_debounce_fsm #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .CNT_W        (CNT_W)
        ) u_fsm (
            .clk      (clk),
            .rst      (rst),
            .push_i   (bus.push[i]),
            .level_o  (level_w[i]),
            .tick_o   (tick_w[i]),
            .release_o(release_w[i])
        );
    end

    assign bus.push_level   = level_w;
    assign bus.push_tick    = tick_w;
    assign bus.push_release = release_w;

endmodule

// File: tb/tb_push_conditioner.sv
// Scoreboard bench for push_conditioner with short timing constants.
// Stimulus queues expected pulses by cycle; a monitor compares every cycle.
module tb_push_conditioner;

    localparam int N_BTN = 3;
    localparam int DB    = 4;
    localparam int RD    = 10;
    localparam int RP    = 3;
    localparam int CW    = 8;

    typedef struct {
        int         cyc;
        logic [2:0] tick;
        logic [2:0] rel;
        logic [2:0] level;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    logic [2:0] exp_level = 3'b000;

    push_conditioner_if #(.N_BTN(N_BTN)) btn_if ();

    push_conditioner #(
        .N_BTN        (N_BTN),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .CNT_W        (CW)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(btn_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: actual=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic expect_ev(input int c, input logic [2:0] t, input logic [2:0] r, input logic [2:0] l);
        exp_q.push_back('{c, t, r, l});
    endtask

    // Returns one tick after the n-th following rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard when a pulse is due, otherwise demands quiet outputs.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                ev = exp_q.pop_front();
                check("missed_event_cycle", cyc, ev.cyc);
                exp_level = ev.level;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev = exp_q.pop_front();
                check("event_tick", btn_if.push_tick, ev.tick);
                check("event_release", btn_if.push_release, ev.rel);
                check("event_level", btn_if.push_level, ev.level);
                exp_level = ev.level;
            end else begin
                check("unexpected_pulse", {btn_if.push_tick, btn_if.push_release}, 32'd0);
                check("level_hold", btn_if.push_level, exp_level);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int b;
        int q;
        btn_if.push = 3'b000;
        wait_cycles(3);
        check("reset_level", btn_if.push_level, 3'b000);
        check("reset_tick", btn_if.push_tick, 3'b000);
        check("reset_release", btn_if.push_release, 3'b000);
        rst = 1'b0;
        wait_cycles(3);

        // Reset while all three buttons are accepted and ticking.
        b = cyc;
        btn_if.push = 3'b111;
        wait_cycles(6);
        check("tick_before_rst", btn_if.push_tick, 3'b111);
        check("level_before_rst", btn_if.push_level, 3'b111);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_level = 3'b000;
        #1;
        check("rst_level_async", btn_if.push_level, 3'b000);
        check("rst_tick_async", btn_if.push_tick, 3'b000);
        check("rst_release_async", btn_if.push_release, 3'b000);
        wait_cycles(2);
        #1;
        rst = 1'b0;
        q = cyc;
        expect_ev(q + 6, 3'b111, 3'b000, 3'b111);
        wait_cycles(8);
        btn_if.push = 3'b000;
        expect_ev(q + 14, 3'b000, 3'b111, 3'b000);
        wait_cycles(12);

        // Three-cycle glitch on button 0 is rejected.
        btn_if.push = 3'b001;
        wait_cycles(3);
        btn_if.push = 3'b000;
        wait_cycles(12);

        // Button 1 held: press, delay, period, then a 2-cycle dropout restarts the delay.
        b = cyc;
        btn_if.push = 3'b010;
        expect_ev(b + 6,  3'b010, 3'b000, 3'b010);
        expect_ev(b + 16, 3'b010, 3'b000, 3'b010);
        expect_ev(b + 19, 3'b010, 3'b000, 3'b010);
        expect_ev(b + 22, 3'b010, 3'b000, 3'b010);
        expect_ev(b + 25, 3'b010, 3'b000, 3'b010);
        // Dropout seen at b+28, HELD re-entered at b+30, repeat delay runs from there.
        expect_ev(b + 40, 3'b010, 3'b000, 3'b010);
        expect_ev(b + 43, 3'b010, 3'b000, 3'b010);
        expect_ev(b + 46, 3'b010, 3'b000, 3'b010);
        expect_ev(b + 50, 3'b000, 3'b010, 3'b000);
        wait_cycles(25);
        btn_if.push = 3'b000;
        wait_cycles(2);
        btn_if.push = 3'b010;
        wait_cycles(17);
        btn_if.push = 3'b000;
        wait_cycles(14);

        // Button 2 held 20 cycles, then released.
        b = cyc;
        btn_if.push = 3'b100;
        expect_ev(b + 6,  3'b100, 3'b000, 3'b100);
        expect_ev(b + 16, 3'b100, 3'b000, 3'b100);
        expect_ev(b + 19, 3'b100, 3'b000, 3'b100);
        expect_ev(b + 22, 3'b100, 3'b000, 3'b100);
        expect_ev(b + 26, 3'b000, 3'b100, 3'b000);
        wait_cycles(20);
        btn_if.push = 3'b000;
        wait_cycles(14);

        // Buttons 0 and 2 together, with a 1-cycle bounce on button 2.
        b = cyc;
        btn_if.push = 3'b101;
        expect_ev(b + 6,  3'b001, 3'b000, 3'b001);
        expect_ev(b + 8,  3'b100, 3'b000, 3'b101);
        expect_ev(b + 16, 3'b000, 3'b101, 3'b000);
        wait_cycles(1);
        btn_if.push = 3'b001;
        wait_cycles(1);
        btn_if.push = 3'b101;
        wait_cycles(8);
        btn_if.push = 3'b000;
        wait_cycles(14);

        check("pending_events", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
